genius_game_fsm: RTL



---
 rtl/genius_game_fsm_if.sv | 23 ++
 rtl/genius_game_fsm.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/genius_game_fsm_if.sv
// Interface between the IR remote decoder / display logic and the Genius game engine.
// The decoder side (master) drives colour, button and ready; the engine side
// (slave) returns the LED pattern, score and status flags.
interface genius_game_fsm_if;
  logic [1:0] cor;
  logic [2:0] botao;
  logic       ready;
  logic [3:0] led;
  logic [5:0] score;
  logic       win;
  logic       game_over;
  logic [2:0] state_dbg;

  modport master (
    output cor, botao, ready,
    input  led, score, win, game_over, state_dbg
  );

  modport slave (
    input  cor, botao, ready,
    output led, score, win, game_over, state_dbg
  );
endinterface

// File: rtl/genius_game_fsm.sv
// Genius (Simon) game engine: grows a random colour sequence one step per round,
// plays it back on four one-hot LEDs, then checks the player's echo from the IR remote.
// Optional feature: define GENIUS_TIMEOUT_EN to make an idle player lose after
// TIMEOUT_CYCLES clocks in WAIT_IN; without it WAIT_IN waits forever.
module genius_game_fsm #(
  parameter int MAX_LEN        = 16,
  parameter int SHOW_CYCLES    = 25000000,
  parameter int GAP_CYCLES     = 12500000,
  parameter int TIMEOUT_CYCLES = 250000000
) (
  input logic              clk_pll,
  input logic              reset,
  genius_game_fsm_if.slave bus
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = $clog2(MAX_LEN);
  localparam logic [31:0]   GAP_LOAD     = 32'(GAP_CYCLES - 1);
  localparam logic [31:0]   SHOW_LOAD    = 32'(SHOW_CYCLES - 1);
  localparam logic [31:0]   TIMEOUT_LOAD = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [LW-1:0] LEN_MAX      = LW'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ADD      = 3'd1,
    S_GAP      = 3'd2,
    S_SHOW_ON  = 3'd3,
    S_SHOW_OFF = 3'd4,
    S_WAIT_IN  = 3'd5,
    S_WIN      = 3'd6,
    S_LOSE     = 3'd7
  } state_t;

  state_t        state, state_n;
  logic [LW-1:0] len, len_n;
  logic [LW-1:0] idx, idx_n;
  logic [31:0]   timer, timer_n;
  logic [5:0]    score, score_n;
  logic          ready_d;
  logic [1:0]    last_col, last_col_n;
  logic          last_vld, last_vld_n;
  logic [1:0]    mem [MAX_LEN];
  logic          mem_we;

  logic          evt;
  logic          is_colour;
  logic          is_start;
  logic [1:0]    code_col;
  logic          col_evt;
  logic          start_evt;
  logic [1:0]    cur_col;
  logic          last_step;

  assign evt       = bus.ready & ~ready_d;
  assign col_evt   = evt & is_colour;
  assign start_evt = evt & is_start;
  assign cur_col   = mem[idx[IW-1:0]];
  assign last_step = (idx == len - 1'b1);

  // Translate the remote's button code into a colour index or a START request.
  always_comb begin
    is_colour = 1'b1;
    is_start  = 1'b0;
    code_col  = 2'd0;
    case (bus.botao)
      3'b100:  code_col = 2'd0;
      3'b011:  code_col = 2'd1;
      3'b110:  code_col = 2'd2;
      3'b010:  code_col = 2'd3;
      3'b001: begin
        is_colour = 1'b0;
        is_start  = 1'b1;
      end
      default: is_colour = 1'b0;
    endcase
  end

  // State and datapath registers; ready_d resets high so a held button is not a press.
  always_ff @(posedge clk_pll) begin
    if (reset) begin
      state    <= S_IDLE;
      len      <= '0;
      idx      <= '0;
      timer    <= '0;
      score    <= '0;
      ready_d  <= 1'b1;
      last_col <= '0;
      last_vld <= 1'b0;
    end else begin
      state    <= state_n;
      len      <= len_n;
      idx      <= idx_n;
      timer    <= timer_n;
      score    <= score_n;
      ready_d  <= bus.ready;
      last_col <= last_col_n;
      last_vld <= last_vld_n;
    end
  end

  // Sequence memory is deliberately not cleared by reset; a new game overwrites it.
  always_ff @(posedge clk_pll) begin
    if (mem_we) begin
      mem[len[IW-1:0]] <= bus.cor;
    end
  end

  // Next-state logic: playback timing, echo checking and game start/end.
  always_comb begin
    state_n    = state;
    len_n      = len;
    idx_n      = idx;
    timer_n    = timer;
    score_n    = score;
    last_col_n = last_col;
    last_vld_n = last_vld;
    mem_we     = 1'b0;
    case (state)
      S_IDLE, S_WIN, S_LOSE: begin
        if (start_evt) begin
          state_n = S_ADD;
          len_n   = '0;
          score_n = '0;
        end
      end
      S_ADD: begin
        mem_we     = ~reset;
        len_n      = len + 1'b1;
        idx_n      = '0;
        timer_n    = GAP_LOAD;
        last_vld_n = 1'b0;
        state_n    = S_GAP;
      end
      S_GAP: begin
        if (timer == '0) begin
          state_n = S_SHOW_ON;
          timer_n = SHOW_LOAD;
        end else begin
          timer_n = timer - 32'd1;
        end
      end
      S_SHOW_ON: begin
        if (timer == '0) begin
          state_n = S_SHOW_OFF;
          timer_n = GAP_LOAD;
        end else begin
          timer_n = timer - 32'd1;
        end
      end
      S_SHOW_OFF: begin
        if (timer == '0) begin
          if (last_step) begin
            idx_n   = '0;
            timer_n = TIMEOUT_LOAD;
            state_n = S_WAIT_IN;
          end else begin
            idx_n   = idx + 1'b1;
            timer_n = SHOW_LOAD;
            state_n = S_SHOW_ON;
          end
        end else begin
          timer_n = timer - 32'd1;
        end
      end
      S_WAIT_IN: begin
`ifdef GENIUS_TIMEOUT_EN
        if (timer != '0) begin
          timer_n = timer - 32'd1;
        end else if (!col_evt) begin
          state_n = S_LOSE;
        end
`endif
        if (col_evt) begin
          last_col_n = code_col;
          last_vld_n = 1'b1;
          timer_n    = TIMEOUT_LOAD;
          if (code_col != cur_col) begin
            state_n = S_LOSE;
          end else if (last_step) begin
            score_n = score + 6'd1;
            idx_n   = '0;
            state_n = (len == LEN_MAX) ? S_WIN : S_ADD;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // LED pattern: playback colour, echo of the pressed colour, or all-on for a win.
  always_comb begin
    bus.led = 4'b0000;
    case (state)
      S_SHOW_ON: bus.led = 4'b0001 << cur_col;
      S_WAIT_IN: begin
        if (bus.ready) begin
          if (col_evt) begin
            bus.led = 4'b0001 << code_col;
          end else if (last_vld) begin
            bus.led = 4'b0001 << last_col;
          end
        end
      end
      S_WIN:     bus.led = 4'b1111;
      default:   bus.led = 4'b0000;
    endcase
  end

  assign bus.score     = score;
  assign bus.win       = (state == S_WIN);
  assign bus.game_over = (state == S_LOSE);
  assign bus.state_dbg = state;

endmodule
